// File: rtl/priority_encoder_pipe.sv
// Registered N:log2(N) priority encoder with fixed or round-robin priority and valid/ready on both sides.
// Define PRIO_ENC_COUNT_EN to add the registered population-count output out_cnt.
module priority_encoder_pipe #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         mode_i,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_any
`ifdef PRIO_ENC_COUNT_EN
    ,
    output logic [$clog2(N+1)-1:0] out_cnt
`endif
);

    localparam int unsigned  NU      = N;
    localparam logic [W-1:0] PTR_RST = W'(N - 1);

    logic [W-1:0] ptr;
    logic [W-1:0] fix_idx;
    logic [W-1:0] rr_idx;
    logic [W-1:0] win;
    logic         any;
    logic         accept;

    // Position reached after 'step' moves down from p, wrapping 0 -> N-1.
    function automatic logic [W-1:0] rr_pos(input logic [W-1:0] p, input int unsigned step);
        int unsigned base;
        base = 32'(p) + NU;
        return W'((base - step) % NU);
    endfunction

    assign any      = |req_i;
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign win      = mode_i ? rr_idx : fix_idx;

    always_comb begin
        fix_idx = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            if (req_i[i]) fix_idx = W'(i);
        end
    end

    always_comb begin
        rr_idx = '0;
        // Walk the search order from its far end so the earliest hit is the last assignment.
        for (int unsigned k = 0; k < NU; k++) begin
            if (req_i[rr_pos(ptr, NU - 1 - k)]) rr_idx = rr_pos(ptr, NU - 1 - k);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_any   <= 1'b0;
            ptr       <= PTR_RST;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_any   <= any;
            out_idx   <= any ? win : '0;
            if (mode_i && any) begin
                ptr <= (win == '0) ? PTR_RST : win - W'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef PRIO_ENC_COUNT_EN
    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] cnt;

    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            cnt = cnt + CW'(req_i[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt <= '0;
        end else if (accept) begin
            out_cnt <= cnt;
        end
    end
`endif

endmodule

// File: tb/tb_priority_encoder_pipe.sv
// Self-checking bench for priority_encoder_pipe: directed vector table, hand-written
// handshake/reset sequences, and randomized traffic against a behavioural model.
module tb_priority_encoder_pipe;

    localparam int N = 8;
    localparam int W = $clog2(N);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req_i = '0;
    logic         mode_i = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_idx;
    logic         out_any;
`ifdef PRIO_ENC_COUNT_EN
    logic [$clog2(N+1)-1:0] out_cnt;
`endif

    priority_encoder_pipe #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .mode_i    (mode_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_any   (out_any)
`ifdef PRIO_ENC_COUNT_EN
        ,
        .out_cnt   (out_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural reference state
    logic m_valid;
    int   m_idx;
    logic m_any;
    int   m_cnt;
    int   m_ptr;

    typedef struct {
        logic [N-1:0] req;
        logic         mode;
        int           idx;
        logic         any;
        int           cnt;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_out(input string nm, input logic v, input int idx, input logic any, input int cnt);
        check({nm, ".valid"}, 32'(out_valid), 32'(v));
        check({nm, ".idx"}, 32'(out_idx), idx);
        check({nm, ".any"}, 32'(out_any), 32'(any));
`ifdef PRIO_ENC_COUNT_EN
        check({nm, ".cnt"}, 32'(out_cnt), cnt);
`else
        if (cnt < 0) $display("negative count %0d", cnt);
`endif
    endtask

    task automatic drive(input logic iv, input logic [N-1:0] r, input logic m, input logic ordy);
        in_valid  = iv;
        req_i     = r;
        mode_i    = m;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        m_valid = 1'b0;
        m_idx   = 0;
        m_any   = 1'b0;
        m_cnt   = 0;
        m_ptr   = N - 1;
    endfunction

    function automatic void model_accept(input logic [N-1:0] r, input logic m);
        int w;
        w = -1;
        if (m) begin
            for (int s = 0; s < N; s++) begin
                int c;
                c = (m_ptr - s + N) % N;
                if (w < 0 && r[c]) w = c;
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (w < 0 && r[i]) w = i;
            end
        end
        m_valid = 1'b1;
        m_any   = (w >= 0);
        m_idx   = m_any ? w : 0;
        m_cnt   = $countones(r);
        if (m && m_any) m_ptr = (w == 0) ? N - 1 : w - 1;
    endfunction

    // Called at posedge+1; pulls reset between edges and checks outputs before any clock.
    task automatic do_reset(input string nm);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #2;
        check_out(nm, 1'b0, 0, 1'b0, 0);
        check({nm, ".in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] r;
        logic         iv, m, ordy, exp_rdy;

        tbl[0]  = '{8'b0010_0110, 1'b0, 5, 1'b1, 3};
        tbl[1]  = '{8'h00,        1'b1, 0, 1'b0, 0};
        tbl[2]  = '{8'hFF,        1'b1, 7, 1'b1, 8};
        tbl[3]  = '{8'hFF,        1'b1, 6, 1'b1, 8};
        tbl[4]  = '{8'hFF,        1'b1, 5, 1'b1, 8};
        tbl[5]  = '{8'hFF,        1'b1, 4, 1'b1, 8};
        tbl[6]  = '{8'b1000_0001, 1'b1, 0, 1'b1, 2};
        tbl[7]  = '{8'b1000_0001, 1'b1, 7, 1'b1, 2};
        tbl[8]  = '{8'hFF,        1'b1, 6, 1'b1, 8};
        tbl[9]  = '{8'hFF,        1'b1, 5, 1'b1, 8};
        tbl[10] = '{8'hFF,        1'b1, 4, 1'b1, 8};
        tbl[11] = '{8'b1000_1000, 1'b0, 7, 1'b1, 2};
        tbl[12] = '{8'b1000_1000, 1'b1, 3, 1'b1, 2};
        tbl[13] = '{8'b0000_0100, 1'b1, 2, 1'b1, 1};
        tbl[14] = '{8'b1000_0000, 1'b1, 7, 1'b1, 1};

        model_reset();
        #2;
        check_out("por", 1'b0, 0, 1'b0, 0);
        check("por.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed table, back-to-back accepts from reset
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, tbl[i].req, tbl[i].mode, 1'b1);
            #1;
            check($sformatf("tbl%0d.in_ready", i), 32'(in_ready), 32'd1);
            tick();
            check_out($sformatf("tbl%0d", i), 1'b1, tbl[i].idx, tbl[i].any, tbl[i].cnt);
        end

        // Backpressure: held result, ignored inputs, pointer untouched
        do_reset("rst_a");
        drive(1'b1, 8'hFF, 1'b1, 1'b1);
        tick();
        check_out("bp.first", 1'b1, 7, 1'b1, 8);
        r = 8'hF0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, r, 1'b1, 1'b0);
            #1;
            check($sformatf("bp.hold%0d.in_ready", c), 32'(in_ready), 32'd0);
            tick();
            check_out($sformatf("bp.hold%0d", c), 1'b1, 7, 1'b1, 8);
            r = {r[N-3:0], r[N-1:N-2]};
        end
        drive(1'b1, 8'hFF, 1'b1, 1'b1);
        #1;
        check("bp.release.in_ready", 32'(in_ready), 32'd1);
        tick();
        check_out("bp.release", 1'b1, 6, 1'b1, 8);

        // Drain with no new input keeps idx/any
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        check_out("drain", 1'b0, 6, 1'b1, 8);

        // Async reset while a result is held
        drive(1'b1, 8'h20, 1'b0, 1'b0);
        tick();
        check_out("pre_rst", 1'b1, 5, 1'b1, 1);
        do_reset("rst_b");
        drive(1'b1, 8'hFF, 1'b1, 1'b1);
        tick();
        check_out("post_rst_ptr", 1'b1, 7, 1'b1, 8);

        // Randomized traffic against the model
        do_reset("rst_c");
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc == 300) do_reset("rst_mid");
            iv   = ($urandom_range(0, 3) != 0);
            r    = N'($urandom);
            case ($urandom_range(0, 3))
                0: r = '0;
                1: r = r & N'($urandom) & N'($urandom);
                default: ;
            endcase
            m    = 1'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            drive(iv, r, m, ordy);
            #1;
            exp_rdy = !m_valid || ordy;
            check($sformatf("rnd%0d.in_ready", cyc), 32'(in_ready), 32'(exp_rdy));
            if (iv && exp_rdy) model_accept(r, m);
            else if (ordy) m_valid = 1'b0;
            tick();
            check($sformatf("rnd%0d.valid", cyc), 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                check($sformatf("rnd%0d.idx", cyc), 32'(out_idx), m_idx);
                check($sformatf("rnd%0d.any", cyc), 32'(out_any), 32'(m_any));
`ifdef PRIO_ENC_COUNT_EN
                check($sformatf("rnd%0d.cnt", cyc), 32'(out_cnt), m_cnt);
`endif
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
